battleship_game_core: RTL and testbench

- Parametrised successor to the fixed 10x10 game_state logic.
- Owns the shot grid, turn counter, per-ship hit tracking and the play/win/lose state machine for an arbitrary ROWS x COLS board with NUM_SHIPS ships.
- Sits between cursor_controller (cursor position), the fire button and the renderer/ssd_controller, which consume cell_status_flat, turns_left and ships_remaining.

---
 rtl/battleship_pkg.sv | 23 ++
 rtl/btn_sync_edge.sv | 36 +++
 rtl/battleship_game_core.sv | 175 +++++++++++++++++
 tb/tb_battleship_game_core.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared constants for the battleship game core: cell status codes and game states.
package battleship_pkg;

    localparam logic [1:0] CELL_UNKNOWN = 2'd0;
    localparam logic [1:0] CELL_MISS    = 2'd1;
    localparam logic [1:0] CELL_HIT     = 2'd2;
    localparam logic [1:0] CELL_REVEAL  = 2'd3;

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WIN   = 2'd2;
    localparam logic [1:0] ST_LOSE  = 2'd3;

    localparam int SHIP_LEN_W = 4;

    typedef enum logic [1:0] {
        GS_PLAY  = ST_PLAY,
        GS_CHECK = ST_CHECK,
        GS_WIN   = ST_WIN,
        GS_LOSE  = ST_LOSE
    } game_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector; a held button yields a single one-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_q, sync2_q, prev_q, pulse_q;
    logic sync1_d, sync2_d, prev_d, pulse_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/battleship_game_core.sv
// Battleship game core: shot grid, turn/ship bookkeeping and PLAY/CHECK/WIN/LOSE FSM.
// Optional two-cell salvo shot is enabled by defining BATTLESHIP_SALVO_EN.
module battleship_game_core
    import battleship_pkg::*;
#(
    parameter int ROWS      = 10,
    parameter int COLS      = 10,
    parameter int NUM_SHIPS = 5,
    parameter int MAX_TURNS = 20,
    parameter int ROW_W     = $clog2(ROWS),
    parameter int COL_W     = $clog2(COLS),
    parameter int ID_W      = $clog2(NUM_SHIPS + 1),
    parameter int TURN_W    = $clog2(MAX_TURNS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fire,
`ifdef BATTLESHIP_SALVO_EN
    input  logic                      salvo,
`endif
    input  logic                      new_game,
    input  logic [ROW_W-1:0]          cursor_row,
    input  logic [COL_W-1:0]          cursor_col,
    input  logic [ROWS*COLS*ID_W-1:0] ship_id_flat,
    input  logic [NUM_SHIPS*4-1:0]    ship_len_flat,
    input  logic                      show_answer,
    output logic [2*ROWS*COLS-1:0]    cell_status_flat,
    output logic [TURN_W-1:0]         turns_left,
    output logic [ID_W-1:0]           ships_remaining,
    output logic [1:0]                game_state,
    output logic                      shot_valid,
    output logic                      shot_hit
);

    localparam int NCELL = ROWS * COLS;
    localparam int IDX_W = $clog2(NCELL);
    localparam int LEN_W = SHIP_LEN_W;

    logic [NCELL-1:0][ID_W-1:0]      ship_id;
    logic [NUM_SHIPS-1:0][LEN_W-1:0] ship_len;
    logic [NCELL-1:0][1:0]           cell_q, cell_d, cell_out;
    game_state_e                     state_q, state_d;
    logic [IDX_W-1:0]                tgt_q, tgt_d;
    logic [TURN_W-1:0]               turns_q, turns_d;
    logic [ID_W-1:0]                 ships_q, ships_d;
    logic [NUM_SHIPS-1:0][LEN_W-1:0] hit_cnt_q, hit_cnt_d;
    logic                            shot_valid_q, shot_valid_d;
    logic                            shot_hit_q, shot_hit_d;
    logic                            salvo_pend_q, salvo_pend_d;

    logic             clear;
    logic             fire_pulse;
    logic             salvo_req;
    logic             in_range;
    logic [IDX_W-1:0] fire_idx;
    logic [IDX_W-1:0] nb_idx;
    logic [ID_W-1:0]  tgt_id;
    logic [ID_W-1:0]  sidx;
    logic             tracked;
    logic [LEN_W-1:0] cnt_inc;

    assign ship_id  = ship_id_flat;
    assign ship_len = ship_len_flat;
    assign clear    = reset | new_game;

    btn_sync_edge u_fire (
        .clk    (clk),
        .reset  (clear),
        .btn_in (fire),
        .pulse  (fire_pulse)
    );

    // Salvo is only meaningful when a right neighbour exists on the board.
`ifdef BATTLESHIP_SALVO_EN
    assign salvo_req = salvo &&
        (({1'b0, cursor_col} + (COL_W+1)'(1)) < (COL_W+1)'(COLS));
`else
    assign salvo_req = 1'b0;
`endif

    assign in_range = ({1'b0, cursor_row} < (ROW_W+1)'(ROWS)) &&
                      ({1'b0, cursor_col} < (COL_W+1)'(COLS));
    assign fire_idx = IDX_W'(cursor_row) * IDX_W'(COLS) + IDX_W'(cursor_col);
    assign nb_idx   = tgt_q + IDX_W'(1);
    assign tgt_id   = ship_id[tgt_q];
    assign tracked  = (tgt_id != '0) && (tgt_id <= ID_W'(NUM_SHIPS));
    assign sidx     = tgt_id - ID_W'(1);
    assign cnt_inc  = hit_cnt_q[sidx] + LEN_W'(1);

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        turns_d      = turns_q;
        ships_d      = ships_q;
        hit_cnt_d    = hit_cnt_q;
        cell_d       = cell_q;
        shot_valid_d = 1'b0;
        shot_hit_d   = 1'b0;
        salvo_pend_d = salvo_pend_q;

        case (state_q)
            GS_PLAY: begin
                if (fire_pulse && in_range && cell_q[fire_idx] == CELL_UNKNOWN) begin
                    tgt_d        = fire_idx;
                    salvo_pend_d = salvo_req;
                    state_d      = GS_CHECK;
                end
            end
            GS_CHECK: begin
                cell_d[tgt_q] = (tgt_id != '0) ? CELL_HIT : CELL_MISS;
                if (turns_q != '0)
                    turns_d = turns_q - TURN_W'(1);
                shot_valid_d = 1'b1;
                shot_hit_d   = (tgt_id != '0);
                // Zero-length ships never sink; saturate so extra cells cannot double-count.
                if (tracked && ship_len[sidx] != '0 && hit_cnt_q[sidx] != ship_len[sidx]) begin
                    hit_cnt_d[sidx] = cnt_inc;
                    if (cnt_inc == ship_len[sidx] && ships_q != '0)
                        ships_d = ships_q - ID_W'(1);
                end
                salvo_pend_d = 1'b0;
                if (ships_d == '0)
                    state_d = GS_WIN;
                else if (turns_d == '0)
                    state_d = GS_LOSE;
                else if (salvo_pend_q && cell_q[nb_idx] == CELL_UNKNOWN) begin
                    tgt_d   = nb_idx;
                    state_d = GS_CHECK;
                end else
                    state_d = GS_PLAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= GS_PLAY;
            tgt_q        <= '0;
            turns_q      <= TURN_W'(MAX_TURNS);
            ships_q      <= ID_W'(NUM_SHIPS);
            hit_cnt_q    <= '0;
            cell_q       <= '0;
            shot_valid_q <= 1'b0;
            shot_hit_q   <= 1'b0;
            salvo_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            turns_q      <= turns_d;
            ships_q      <= ships_d;
            hit_cnt_q    <= hit_cnt_d;
            cell_q       <= cell_d;
            shot_valid_q <= shot_valid_d;
            shot_hit_q   <= shot_hit_d;
            salvo_pend_q <= salvo_pend_d;
        end
    end

    // Reveal is display-only; the stored grid never holds CELL_REVEAL.
    always_comb begin
        for (int k = 0; k < NCELL; k++) begin
            cell_out[k] = (cell_q[k] == CELL_UNKNOWN && ship_id[k] != '0 && show_answer)
                          ? CELL_REVEAL : cell_q[k];
        end
    end

    assign cell_status_flat = cell_out;
    assign turns_left       = turns_q;
    assign ships_remaining  = ships_q;
    assign game_state       = state_q;
    assign shot_valid       = shot_valid_q;
    assign shot_hit         = shot_hit_q;

endmodule

// File: tb/tb_battleship_game_core.sv
// Scoreboard bench for battleship_game_core: shots push expected outcomes from a
// board-level model; a monitor pops and compares on every shot_valid.
module tb_battleship_game_core;

    localparam int ROWS      = 10;
    localparam int COLS      = 10;
    localparam int NUM_SHIPS = 5;
    localparam int MAX_TURNS = 20;
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);
    localparam int ID_W      = $clog2(NUM_SHIPS + 1);
    localparam int TURN_W    = $clog2(MAX_TURNS + 1);
    localparam int NCELL     = ROWS * COLS;

    logic                    clk = 1'b0;
    logic                    reset, fire, new_game, show_answer;
`ifdef BATTLESHIP_SALVO_EN
    logic                    salvo = 1'b0;
`endif
    logic [ROW_W-1:0]        cursor_row;
    logic [COL_W-1:0]        cursor_col;
    logic [NCELL*ID_W-1:0]   ship_id_flat;
    logic [NUM_SHIPS*4-1:0]  ship_len_flat;
    logic [2*NCELL-1:0]      cell_status_flat;
    logic [TURN_W-1:0]       turns_left;
    logic [ID_W-1:0]         ships_remaining;
    logic [1:0]              game_state;
    logic                    shot_valid, shot_hit;

    battleship_game_core #(
        .ROWS(ROWS), .COLS(COLS), .NUM_SHIPS(NUM_SHIPS), .MAX_TURNS(MAX_TURNS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fire             (fire),
`ifdef BATTLESHIP_SALVO_EN
        .salvo            (salvo),
`endif
        .new_game         (new_game),
        .cursor_row       (cursor_row),
        .cursor_col       (cursor_col),
        .ship_id_flat     (ship_id_flat),
        .ship_len_flat    (ship_len_flat),
        .show_answer      (show_answer),
        .cell_status_flat (cell_status_flat),
        .turns_left       (turns_left),
        .ships_remaining  (ships_remaining),
        .game_state       (game_state),
        .shot_valid       (shot_valid),
        .shot_hit         (shot_hit)
    );

    always #5 clk = ~clk;

    // Reference model: which ship sits where and which cells have been shot.
    int id_of [NCELL];
    bit shot  [NCELL];
    int lens  [NUM_SHIPS];
    int m_shots;
    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    typedef struct {
        int idx;
        int hit;
        int turns;
        int ships;
        int st;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ships_left();
        int n = 0;
        for (int s = 1; s <= NUM_SHIPS; s++) begin
            bit afloat = 0;
            for (int k = 0; k < NCELL; k++)
                if (id_of[k] == s && !shot[k]) afloat = 1;
            if (afloat) n++;
        end
        return n;
    endfunction

    function automatic int m_state();
        if (ships_left() == 0) return 2;
        if (m_shots >= MAX_TURNS) return 3;
        return 0;
    endfunction

    function automatic int exp_cell(input int k);
        if (shot[k]) return (id_of[k] != 0) ? 2 : 1;
        if (show_answer && id_of[k] != 0) return 3;
        return 0;
    endfunction

    task automatic check_board(input string tag);
        int bad = 0;
        for (int k = 0; k < NCELL; k++)
            if (int'(cell_status_flat[2*k +: 2]) != exp_cell(k)) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_turns"}, int'(turns_left), MAX_TURNS - m_shots);
        chk({tag, "_ships"}, int'(ships_remaining), ships_left());
        chk({tag, "_state"}, int'(game_state), m_state());
        chk({tag, "_valid"}, int'(shot_valid), 0);
        check_board({tag, "_board"});
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCELL; k++) shot[k] = 0;
        m_shots = 0;
    endtask

    task automatic model_fire(input int r, input int c);
        int idx;
        exp_t e;
        idx = r * COLS + c;
        if (m_state() == 0 && r < ROWS && c < COLS && !shot[idx]) begin
            shot[idx] = 1;
            m_shots++;
            e.idx   = idx;
            e.hit   = (id_of[idx] != 0) ? 1 : 0;
            e.turns = MAX_TURNS - m_shots;
            e.ships = ships_left();
            e.st    = m_state();
            sb.push_back(e);
        end
    endtask

    task automatic shoot(input int r, input int c, input int hold);
        int rr, cc;
        rr = r;
        cc = c;
        cursor_row = rr[ROW_W-1:0];
        cursor_col = cc[COL_W-1:0];
        model_fire(r, c);
        fire = 1'b1;
        repeat (hold) @(posedge clk);
        #1 fire = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic start_new_game();
        @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic place(input int id, input int r, input int c, input int len, input bit vert);
        for (int i = 0; i < len; i++)
            id_of[vert ? (r + i) * COLS + c : r * COLS + c + i] = id;
        lens[id-1] = len;
    endtask

    task automatic build_board();
        int v;
        for (int k = 0; k < NCELL; k++) id_of[k] = 0;
        place(1, 3, 4, 2, 0);
        place(2, 5, 0, 3, 0);
        place(3, 0, 9, 3, 1);
        place(4, 8, 3, 4, 0);
        place(5, 1, 1, 5, 0);
        for (int k = 0; k < NCELL; k++) begin
            v = id_of[k];
            ship_id_flat[k*ID_W +: ID_W] = v[ID_W-1:0];
        end
        for (int i = 0; i < NUM_SHIPS; i++) begin
            v = lens[i];
            ship_len_flat[i*4 +: 4] = v[3:0];
        end
    endtask

    // Monitor: every resolved shot must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && shot_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_shot_valid actual=1 expected=0 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                chk("sb_hit",   int'(shot_hit), e.hit);
                chk("sb_turns", int'(turns_left), e.turns);
                chk("sb_ships", int'(ships_remaining), e.ships);
                chk("sb_state", int'(game_state), e.st);
                chk("sb_cell",  int'(cell_status_flat[2*e.idx +: 2]), e.hit ? 2 : 1);
            end
        end
    end

    always @(negedge clk) if (dut.fire_pulse) pulse_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, got, p0, guard, seen, k, j, tmp;
        int cells[$];
        int miss[$];

        reset = 1'b1; fire = 1'b0; new_game = 1'b0; show_answer = 1'b0;
        cursor_row = '0; cursor_col = '0;
        build_board();
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_state("reset");
        chk("reset_hit", int'(shot_hit), 0);

        show_answer = 1'b1; #1;
        check_board("reveal");
        show_answer = 1'b0; #1;
        check_board("unreveal");

        // First shot on water with latency measured from the fire edge.
        @(posedge clk); #1;
        cursor_row = '0; cursor_col = '0;
        model_fire(0, 0);
        fire = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (shot_valid) got = 1;
        end
        chk("first_latency", lat, 5);
        #1 fire = 1'b0;
        repeat (8) @(posedge clk); #1;

        shoot(3, 4, 2);
        chk("first_hit_ships", int'(ships_remaining), NUM_SHIPS);
        shoot(3, 5, 3);
        chk("sink_ships", int'(ships_remaining), NUM_SHIPS - 1);

        p0 = pulse_cnt;
        shoot(3, 4, 100);
        chk("refire_pulses", pulse_cnt - p0, 1);
        chk("refire_turns", int'(turns_left), MAX_TURNS - m_shots);

        shoot(12, 3, 2);
        shoot(4, 11, 3);
        check_state("out_of_range");
        chk("sb_drained_a", sb.size(), 0);

        // Random shots (some off-board or repeated) until the game ends.
        guard = 0;
        while (m_state() == 0 && guard < 300) begin
            shoot($urandom_range(11, 0), $urandom_range(11, 0), $urandom_range(5, 1));
            guard++;
        end
        check_state("game1_end");
        shoot($urandom_range(9, 0), $urandom_range(9, 0), 3);
        check_state("fire_after_end");

        start_new_game();
        check_state("new_game");

        // Win on the very last turn: misses first, final shot sinks the final ship.
        while (miss.size() < MAX_TURNS - 17) begin
            k = $urandom_range(NCELL - 1, 0);
            if (id_of[k] == 0 && !(k inside {miss})) miss.push_back(k);
        end
        for (int i = 0; i < NCELL; i++) if (id_of[i] != 0) cells.push_back(i);
        for (int i = cells.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = cells[i]; cells[i] = cells[j]; cells[j] = tmp;
        end
        foreach (miss[i])  shoot(miss[i] / COLS, miss[i] % COLS, $urandom_range(4, 1));
        foreach (cells[i]) shoot(cells[i] / COLS, cells[i] % COLS, $urandom_range(4, 1));
        check_state("win_last_turn");
        chk("win_code", int'(game_state), 2);

        start_new_game();
        check_state("new_game2");

        // Reset asserted while the FSM is in CHECK.
        @(posedge clk); #1;
        cursor_row = 4'd3; cursor_col = 4'd4;
        fire = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (game_state == 2'd1) seen = 1;
        end
        chk("mid_check_seen", seen, 1);
        reset = 1'b1;
        fire = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check_state("mid_check_reset");
        chk("mid_check_hit", int'(shot_hit), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_state("post_reset");
        chk("sb_drained_b", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
